// File: rtl/accel_pkg.sv
// accel_pkg
//   Shared types and helpers for the accelerator datapath.
//   - comp_op_t  : operation selector for the shared vector engine
//   - tw_t       : 2-bit ternary weight {neg, nz}; TW_NZ / TW_NEG give bit positions
//   - sat_narrow : narrows a wide signed value to w bits, saturating or wrapping
package accel_pkg;

  typedef enum logic [1:0] {
    COMP_ADD    = 2'd0,
    COMP_SUB    = 2'd1,
    COMP_MUL    = 2'd2,
    COMP_MATVEC = 2'd3
  } comp_op_t;

  // Ternary weight: nz=0 -> 0, nz=1/neg=0 -> +1, nz=1/neg=1 -> -1
  typedef logic [1:0] tw_t;

  localparam int unsigned TW_NZ  = 32'd0;
  localparam int unsigned TW_NEG = 32'd1;

  // Returns x clamped to the signed w-bit range when sat=1, else x untouched.
  // Callers keep the low w bits, so the untouched path is a modulo-2^w wrap.
  function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] x,
                                                    input int unsigned      w,
                                                    input logic             sat);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    logic signed [63:0] res;
    max_v = (64'sd1 <<< (w - 32'd1)) - 64'sd1;
    min_v = -(64'sd1 <<< (w - 32'd1));
    if (sat == 1'b0) begin
      res = x;
    end else if (x > max_v) begin
      res = max_v;
    end else if (x < min_v) begin
      res = min_v;
    end else begin
      res = x;
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_shared_vector_engine_arbiter.sv
// rr_arbiter
//   Combinational round-robin arbiter. The search starts at last_i+1 and
//   wraps, so the most recent winner has the lowest priority.
//   Ports:
//     req_i   [N]      request vector
//     last_i  [IDX_W]  index of the previous winner
//     grant_o [N]      one-hot winner (all zero when no request)
//     idx_o   [IDX_W]  binary index of the winner
//     valid_o          at least one request present
module rr_arbiter
  import accel_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic [IDX_W-1:0] cand_s;
  logic             found_s;
  logic             hit_s;

  // Walk the N candidates in priority order; the first requester wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found_s = 1'b0;
    hit_s   = 1'b0;
    cand_s  = '0;
    valid_o = |req_i;
    for (int k = 1; k <= N; k++) begin
      cand_s          = IDX_W'((int'(last_i) + k) % N);
      hit_s           = !found_s && req_i[cand_s];
      grant_o[cand_s] = hit_s;
      idx_o           = hit_s ? cand_s : idx_o;
      found_s         = found_s | hit_s;
    end
  end

endmodule

// File: rtl/rr_shared_vector_engine.sv
// rr_shared_vector_engine
//   Shared vector / ternary-matrix engine for NUM_UNITS requesters.
//   A round-robin winner's operands are latched, one result element is
//   produced per cycle for VLEN cycles, then the whole vector is presented
//   with the winner's ID for one cycle.
//   Ports:
//     clk, rst_n                 clock, synchronous active-low reset
//     req      [NUM_UNITS]       per-unit request (level)
//     op_type  [NUM_UNITS]       per-unit operation
//     vec_a    [NUM_UNITS][VLEN] operand A
//     vec_b    [NUM_UNITS][VLEN] operand B (unused by MATVEC)
//     mat      [NUM_UNITS][VLEN][VLEN] ternary matrix [row][col]
//     ready                      idle, requests sampled this cycle
//     grant    [NUM_UNITS]       one-cycle one-hot: that unit's operands taken
//     busy                       computation running
//     done                       one-cycle pulse: result valid
//     done_id                    owner of result
//     result   [VLEN]            result vector, held until the next done
module rr_shared_vector_engine
  import accel_pkg::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int VLEN      = 16,
  parameter int W         = 16,
  parameter int FRAC_BITS = 0,
  parameter int SATURATE  = 1,
  parameter int ID_W      = $clog2(NUM_UNITS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_UNITS-1:0] req,
  input  comp_op_t            op_type [NUM_UNITS],
  input  logic signed [W-1:0] vec_a   [NUM_UNITS][VLEN],
  input  logic signed [W-1:0] vec_b   [NUM_UNITS][VLEN],
  input  tw_t                 mat     [NUM_UNITS][VLEN][VLEN],
  output logic                ready,
  output logic [NUM_UNITS-1:0] grant,
  output logic                busy,
  output logic                done,
  output logic [ID_W-1:0]     done_id,
  output logic signed [W-1:0] result  [VLEN]
);

  localparam int IDX_W = $clog2(VLEN);
  // One sign bit plus log2(VLEN) growth bits: a full row never overflows.
  localparam int ACC_W = W + $clog2(VLEN) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [IDX_W-1:0]        IDX_LAST = IDX_W'(VLEN - 1);
  localparam logic signed [ACC_W-1:0] ACC_ZERO = '0;

  logic [1:0]          state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ID_W-1:0]     last_q;
  logic [NUM_UNITS-1:0] grant_q;
  logic [ID_W-1:0]     done_id_q;

  comp_op_t            op_q;
  logic signed [W-1:0] a_q      [VLEN];
  logic signed [W-1:0] b_q      [VLEN];
  tw_t                 mat_q    [VLEN][VLEN];
  logic signed [W-1:0] buf_q    [VLEN];
  logic signed [W-1:0] buf_d    [VLEN];
  logic signed [W-1:0] result_q [VLEN];

  logic [NUM_UNITS-1:0] arb_grant_s;
  logic [ID_W-1:0]      arb_idx_s;
  logic                 arb_valid_s;

  logic signed [63:0]      a_x_s, b_x_s, wide_s;
  logic signed [ACC_W-1:0] acc_s, term_s;
  tw_t                     tw_s;
  logic signed [W-1:0]     elem_s;

  rr_arbiter #(
    .N     (NUM_UNITS),
    .IDX_W (ID_W)
  ) u_arb (
    .req_i   (req),
    .last_i  (last_q),
    .grant_o (arb_grant_s),
    .idx_o   (arb_idx_s),
    .valid_o (arb_valid_s)
  );

  // Next-state and element index for the IDLE -> BUSY -> DONE sequence.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid_s) begin
          state_d = ST_BUSY;
          idx_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        idx_d = idx_q + IDX_W'(32'd1);
        if (idx_q == IDX_LAST) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Element datapath: one result element for index idx_q.
  always_comb begin
    a_x_s  = 64'(a_q[idx_q]);
    b_x_s  = 64'(b_q[idx_q]);
    acc_s  = ACC_ZERO;
    term_s = ACC_ZERO;
    tw_s   = 2'b00;
    wide_s = 64'sd0;
    case (op_q)
      COMP_ADD: wide_s = a_x_s + b_x_s;
      COMP_SUB: wide_s = a_x_s - b_x_s;
      // Full-width product first, then drop fraction bits with sign kept.
      COMP_MUL: wide_s = (a_x_s * b_x_s) >>> FRAC_BITS;
      COMP_MATVEC: begin
        // Negation happens at ACC_W bits so -(-2^(W-1)) stays representable.
        for (int c = 0; c < VLEN; c++) begin
          tw_s   = mat_q[idx_q][c];
          term_s = tw_s[TW_NZ] ? (tw_s[TW_NEG] ? -(ACC_W'(a_q[c])) : ACC_W'(a_q[c]))
                               : ACC_ZERO;
          acc_s  = acc_s + term_s;
        end
        wide_s = 64'(acc_s);
      end
      default: wide_s = 64'sd0;
    endcase
    elem_s = W'(sat_narrow(wide_s, W, (SATURATE != 0)));
  end

  // Result buffer with the current element merged in, so the final element
  // is captured into result on the same edge that enters DONE.
  always_comb begin
    buf_d        = buf_q;
    buf_d[idx_q] = elem_s;
  end

  // Control registers: FSM, element index, round-robin pointer, grant pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      last_q  <= ID_W'(NUM_UNITS - 1);
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      grant_q <= '0;
      if (state_q == ST_IDLE && arb_valid_s) begin
        last_q  <= arb_idx_s;
        grant_q <= arb_grant_s;
      end
    end
  end

  // Operand latch, result buffer and presented result/owner.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q      <= COMP_ADD;
      done_id_q <= '0;
      for (int i = 0; i < VLEN; i++) begin
        a_q[i]      <= '0;
        b_q[i]      <= '0;
        buf_q[i]    <= '0;
        result_q[i] <= '0;
        for (int c = 0; c < VLEN; c++) begin
          mat_q[i][c] <= 2'b00;
        end
      end
    end else begin
      if (state_q == ST_IDLE && arb_valid_s) begin
        op_q  <= op_type[arb_idx_s];
        a_q   <= vec_a[arb_idx_s];
        b_q   <= vec_b[arb_idx_s];
        mat_q <= mat[arb_idx_s];
      end
      if (state_q == ST_BUSY) begin
        buf_q <= buf_d;
        if (idx_q == IDX_LAST) begin
          result_q  <= buf_d;
          done_id_q <= last_q;
        end
      end
    end
  end

  assign ready   = (state_q == ST_IDLE);
  assign busy    = (state_q == ST_BUSY);
  assign done    = (state_q == ST_DONE);
  assign grant   = grant_q;
  assign done_id = done_id_q;
  assign result  = result_q;

endmodule

// File: tb/tb_rr_shared_vector_engine.sv
// Scoreboard bench: instance 0 saturates with FRAC_BITS=0, instance 1 wraps
// with FRAC_BITS=8. Stimulus pushes expected results; a negedge monitor
// checks every grant and done against the queue front.
module tb_rr_shared_vector_engine;
  import accel_pkg::*;

  localparam int NU = 4;
  localparam int VL = 16;
  localparam int WW = 16;

  typedef struct {
    int          inst;
    int          id;
    logic [15:0] r [VL];
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   gcyc [2];
  logic [NU-1:0] pg [2];

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [NU-1:0]        req0, req1;
  comp_op_t             op0 [NU], op1 [NU];
  logic signed [WW-1:0] a0 [NU][VL], b0 [NU][VL], a1 [NU][VL], b1 [NU][VL];
  tw_t                  m0 [NU][VL][VL], m1 [NU][VL][VL];
  logic                 rdy0, rdy1, bsy0, bsy1, dn0, dn1;
  logic [NU-1:0]        gnt0, gnt1;
  logic [1:0]           did0, did1;
  logic signed [WW-1:0] res0 [VL], res1 [VL];

  rr_shared_vector_engine #(.NUM_UNITS(NU), .VLEN(VL), .W(WW), .FRAC_BITS(0), .SATURATE(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .op_type(op0), .vec_a(a0), .vec_b(b0), .mat(m0),
    .ready(rdy0), .grant(gnt0), .busy(bsy0), .done(dn0), .done_id(did0), .result(res0));

  rr_shared_vector_engine #(.NUM_UNITS(NU), .VLEN(VL), .W(WW), .FRAC_BITS(8), .SATURATE(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .op_type(op1), .vec_a(a1), .vec_b(b1), .mat(m1),
    .ready(rdy1), .grant(gnt1), .busy(bsy1), .done(dn1), .done_id(did1), .result(res1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic mon(int k, logic [NU-1:0] g, logic d, logic [1:0] did, logic signed [15:0] r [VL]);
    exp_t e;
    int   bad;
    if (g != 4'b0000) begin
      n_tests++;
      if (exp_q.size() == 0 || exp_q[0].inst != k || g != (4'b0001 << exp_q[0].id) || pg[k] != 4'b0000) begin
        n_fail++;
        $display("FAIL grant%0d: got %b (prev %b) expected unit %0d", k, g, pg[k],
                 (exp_q.size() > 0) ? exp_q[0].id : -1);
      end
      gcyc[k] = cyc;
    end
    pg[k] = g;
    if (d) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL done%0d: unexpected done id=%0d", k, did);
      end else begin
        e   = exp_q.pop_front();
        bad = -1;
        for (int i = VL - 1; i >= 0; i--) begin
          if (r[i] !== e.r[i]) bad = i;
        end
        if (e.inst != k || did != e.id[1:0] || bad >= 0 || (cyc - gcyc[k]) != 16) begin
          n_fail++;
          $display("FAIL done%0d: id %0d exp %0d, lat %0d exp 16, first bad elem %0d got %0h exp %0h",
                   k, did, e.id, cyc - gcyc[k], bad, (bad >= 0) ? r[bad] : 16'h0,
                   (bad >= 0) ? e.r[bad] : 16'h0);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, gnt0, dn0, did0, res0);
    mon(1, gnt1, dn1, did1, res1);
  end

  task automatic ld(int k, int u, comp_op_t o, logic signed [15:0] av [VL], logic signed [15:0] bv [VL]);
    for (int i = 0; i < VL; i++) begin
      for (int c = 0; c < VL; c++) begin
        if (k == 0) m0[u][i][c] = 2'b00; else m1[u][i][c] = 2'b00;
      end
      if (k == 0) begin a0[u][i] = av[i]; b0[u][i] = bv[i]; end
      else begin a1[u][i] = av[i]; b1[u][i] = bv[i]; end
    end
    if (k == 0) op0[u] = o; else op1[u] = o;
  endtask

  task automatic set_w(int k, int u, int r, int c, tw_t t);
    if (k == 0) m0[u][r][c] = t; else m1[u][r][c] = t;
  endtask

  task automatic set_req(int k, int u, logic v);
    if (k == 0) req0[u] = v; else req1[u] = v;
  endtask

  task automatic scramble(int k, int u);
    for (int i = 0; i < VL; i++) begin
      for (int c = 0; c < VL; c++) set_w(k, u, i, c, tw_t'($urandom_range(3, 0)));
      if (k == 0) begin a0[u][i] = 16'($urandom); b0[u][i] = 16'($urandom); end
      else begin a1[u][i] = 16'($urandom); b1[u][i] = 16'($urandom); end
    end
    if (k == 0) op0[u] = comp_op_t'($urandom_range(3, 0)); else op1[u] = comp_op_t'($urandom_range(3, 0));
  endtask

  task automatic wait_grant(int k, int u);
    int t = 0;
    logic [NU-1:0] g;
    do begin
      @(negedge clk);
      t++;
      g = (k == 0) ? gnt0 : gnt1;
    end while (g[u] == 1'b0 && t < 100);
    if (g[u] == 1'b0) begin
      n_tests++;
      n_fail++;
      $display("FAIL grant_timeout%0d: unit %0d never granted", k, u);
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic issue(int k, int u, exp_t e);
    exp_q.push_back(e);
    set_req(k, u, 1'b1);
    wait_grant(k, u);
    set_req(k, u, 1'b0);
    scramble(k, u);
    wait_drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t                 e;
    exp_t                 e2;
    logic signed [15:0]   va [VL];
    logic signed [15:0]   vb [VL];
    logic [15:0]          orr;
    int                   c_prev;
    int                   order [5];
    comp_op_t             o;

    req0 = 4'b0000;
    req1 = 4'b0000;
    gcyc[0] = 0; gcyc[1] = 0; pg[0] = 4'b0000; pg[1] = 4'b0000;
    for (int i = 0; i < VL; i++) begin va[i] = 16'sd0; vb[i] = 16'sd0; end
    for (int u = 0; u < NU; u++) begin ld(0, u, COMP_ADD, va, vb); ld(1, u, COMP_ADD, va, vb); end

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    orr = 16'h0000;
    for (int i = 0; i < VL; i++) orr = orr | res0[i];
    chk("rst_ready", 32'(rdy0), 32'd1);
    chk("rst_busy", 32'(bsy0), 32'd0);
    chk("rst_done", 32'(dn0), 32'd0);
    chk("rst_grant", 32'(gnt0), 32'd0);
    chk("rst_done_id", 32'(did0), 32'd0);
    chk("rst_result", 32'(orr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Unit 2 alone: ADD a=i, b=100
    for (int i = 0; i < VL; i++) begin va[i] = 16'(i); vb[i] = 16'sd100; e.r[i] = 16'(100 + i); end
    ld(0, 2, COMP_ADD, va, vb);
    e.inst = 0; e.id = 2;
    issue(0, 2, e);

    // Reset in the middle of BUSY (idx=5): aborted, no done
    for (int i = 0; i < VL; i++) begin va[i] = 16'sd7; vb[i] = 16'sd7; end
    ld(0, 1, COMP_ADD, va, vb);
    e.inst = 0; e.id = 1;
    exp_q.push_back(e);
    set_req(0, 1, 1'b1);
    wait_grant(0, 1);
    set_req(0, 1, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("mid_busy", 32'(bsy0), 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_ready", 32'(rdy0), 32'd1);
    chk("abort_busy", 32'(bsy0), 32'd0);
    chk("abort_done", 32'(dn0), 32'd0);
    repeat (20) @(negedge clk);

    // After reset, units 0 and 3 request: pointer restarts at unit 0
    for (int i = 0; i < VL; i++) begin va[i] = 16'(2 * i); vb[i] = 16'(-i); e.r[i] = 16'(i); end
    ld(0, 0, COMP_ADD, va, vb);
    e.inst = 0; e.id = 0;
    for (int i = 0; i < VL; i++) begin va[i] = 16'sd1000; vb[i] = 16'(i); e2.r[i] = 16'(1000 - i); end
    ld(0, 3, COMP_SUB, va, vb);
    e2.inst = 0; e2.id = 3;
    exp_q.push_back(e);
    exp_q.push_back(e2);
    req0 = 4'b1001;
    wait_grant(0, 0);
    set_req(0, 0, 1'b0);
    scramble(0, 0);
    wait_grant(0, 3);
    set_req(0, 3, 1'b0);
    scramble(0, 3);
    wait_drain();

    // All units held: order 0,1,2,3,0 with 18-cycle spacing
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
    for (int u = 0; u < NU; u++) begin
      for (int i = 0; i < VL; i++) begin va[i] = 16'(u * 100 + i); vb[i] = 16'sd1; end
      ld(0, u, COMP_ADD, va, vb);
    end
    for (int n = 0; n < 5; n++) begin
      e.inst = 0; e.id = order[n];
      for (int i = 0; i < VL; i++) e.r[i] = 16'(order[n] * 100 + i + 1);
      exp_q.push_back(e);
    end
    req0 = 4'b1111;
    c_prev = 0;
    for (int n = 0; n < 5; n++) begin
      wait_grant(0, order[n]);
      if (n > 0) chk("rr_spacing", 32'(cyc - c_prev), 32'd18);
      c_prev = cyc;
    end
    req0 = 4'b0000;
    wait_drain();

    // ADD/SUB boundaries, saturating (inst 0) and wrapping (inst 1)
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 2; s++) begin
        o = (s == 0) ? COMP_ADD : COMP_SUB;
        for (int i = 0; i < VL; i++) begin
          va[i] = 16'(i); vb[i] = 16'(i);
          e.r[i] = (s == 0) ? 16'(2 * i) : 16'h0000;
        end
        if (s == 0) begin
          va[0] = 16'sh7FFF; vb[0] = 16'sd1;
          va[1] = 16'sh8000; vb[1] = -16'sd1;
          e.r[0] = (k == 0) ? 16'h7FFF : 16'h8000;
          e.r[1] = (k == 0) ? 16'h8000 : 16'h7FFF;
        end else begin
          va[0] = 16'sh8000; vb[0] = 16'sd1;
          va[1] = 16'sh7FFF; vb[1] = -16'sd1;
          e.r[0] = (k == 0) ? 16'h8000 : 16'h7FFF;
          e.r[1] = (k == 0) ? 16'h7FFF : 16'h8000;
        end
        ld(k, 1, o, va, vb);
        e.inst = k; e.id = 1;
        issue(k, 1, e);
      end
    end

    // MATVEC a=1000: row0 +, row1 -, rest 0 (same for both instances)
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < VL; i++) begin va[i] = 16'sd1000; vb[i] = 16'(i * 37); e.r[i] = 16'h0000; end
      ld(k, 3, COMP_MATVEC, va, vb);
      for (int c = 0; c < VL; c++) begin set_w(k, 3, 0, c, 2'b01); set_w(k, 3, 1, c, 2'b11); end
      e.r[0] = 16'h3E80; e.r[1] = 16'hC180;
      e.inst = k; e.id = 3;
      issue(k, 3, e);
    end

    // MATVEC overflow rows and negation of the most negative element
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < VL; i++) begin va[i] = 16'sd30000; vb[i] = 16'sd0; e.r[i] = 16'h0000; end
      va[0] = 16'sh8000;
      ld(k, 0, COMP_MATVEC, va, vb);
      for (int c = 1; c < VL; c++) begin set_w(k, 0, 0, c, 2'b01); set_w(k, 0, 1, c, 2'b11); end
      set_w(k, 0, 2, 0, 2'b11);
      set_w(k, 0, 3, 0, 2'b01);
      set_w(k, 0, 3, 1, 2'b01);
      e.r[0] = (k == 0) ? 16'h7FFF : 16'hDDD0;
      e.r[1] = (k == 0) ? 16'h8000 : 16'h2230;
      e.r[2] = (k == 0) ? 16'h7FFF : 16'h8000;
      e.r[3] = 16'hF530;
      e.inst = k; e.id = 0;
      issue(k, 0, e);
    end

    // MUL with FRAC_BITS=8, wrap (inst 1): 1.5 * -2.0 = -3.0
    for (int i = 0; i < VL; i++) begin va[i] = 16'sh0200; vb[i] = 16'sh0080; e.r[i] = 16'h0100; end
    va[0] = 16'sh0180; vb[0] = 16'shFE00; e.r[0] = 16'hFD00;
    va[1] = 16'sh7FFF; vb[1] = 16'sh7FFF; e.r[1] = 16'hFF00;
    ld(1, 2, COMP_MUL, va, vb);
    e.inst = 1; e.id = 2;
    issue(1, 2, e);

    // MUL with FRAC_BITS=0, saturating (inst 0)
    for (int i = 0; i < VL; i++) begin va[i] = 16'(i); vb[i] = 16'sd2; e.r[i] = 16'(2 * i); end
    va[0] = 16'sd300;  vb[0] = 16'sd200; e.r[0] = 16'h7FFF;
    va[1] = -16'sd3;   vb[1] = 16'sd4;   e.r[1] = 16'hFFF4;
    va[2] = -16'sd300; vb[2] = 16'sd200; e.r[2] = 16'h8000;
    ld(0, 2, COMP_MUL, va, vb);
    e.inst = 0; e.id = 2;
    issue(0, 2, e);

    chk("final_idle0", 32'(rdy0), 32'd1);
    chk("final_idle1", 32'(rdy1), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
